// File: rtl/exp_golomb_packer_if.sv
// exp_golomb_packer_if
//   Bundle of the symbol-in / word-out handshakes of the exp-Golomb packer.
//   master : the side that produces symbols and consumes words (scan / writer glue)
//   slave  : the packer itself
//   Signals:
//     in_valid / in_ready        symbol handshake, in_value (19b) and in_k (3b) payload
//     flush_req                  single-cycle drain request
//     out_valid / out_ready      word handshake, out_data (32b, earliest bit in [31])
//     out_last                   marks the final (padded) word of a flush
//     flush_done                 one-cycle pulse when a flush has completed
//     bits_total                 running count of accepted codeword bits (wraps)
interface exp_golomb_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [18:0] in_value;
  logic [2:0]  in_k;
  logic        flush_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        flush_done;
  logic [31:0] bits_total;

  modport master (
    output in_valid, in_value, in_k, flush_req, out_ready,
    input  in_ready, out_valid, out_data, out_last, flush_done, bits_total
  );

  modport slave (
    input  in_valid, in_value, in_k, flush_req, out_ready,
    output in_ready, out_valid, out_data, out_last, flush_done, bits_total
  );
endinterface

// File: rtl/exp_golomb_packer.sv
// exp_golomb_packer
//   Forms exp-Golomb codewords (value + 2^k, length 2q+k+1) from incoming
//   symbols, appends them MSB-first into a left-justified bit accumulator and
//   emits packed 32-bit words. A flush drains the remainder with zero padding
//   and tags the final word with out_last.
//   Ports:
//     clk      clock
//     reset_n  asynchronous active-low reset
//     bus      exp_golomb_packer_if.slave (symbol in, word out, flush, status)
module exp_golomb_packer #(
  parameter int OUT_W = 32,
  parameter int ACC_W = 72
) (
  input  logic                 clk,
  input  logic                 reset_n,
  exp_golomb_packer_if.slave   bus
);

  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam logic [FILL_W-1:0] WORD_BITS = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] ACC_BITS  = FILL_W'(ACC_W);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Index of the highest set bit; the codeword sum is never zero.
  function automatic logic [4:0] msb_index(input logic [19:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 20; i++) begin
      if (v[i]) begin
        idx = 5'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Codeword length 2q+k+1 with q = msb - k, i.e. 2*msb - k + 1.
  function automatic logic [5:0] code_len(input logic [4:0] msb, input logic [2:0] k);
    return {msb, 1'b0} + 6'd1 - {3'b000, k};
  endfunction

  logic [ACC_W-1:0]  acc_r, acc_n_s;
  logic [FILL_W-1:0] fill_r, fill_n_s;
  logic [1:0]        state_r, state_n_s;
  logic              flush_pend_r, flush_pend_n_s;
  logic [31:0]       bits_total_r;
  logic              alive_r;

  logic [19:0]       sum_s;
  logic [5:0]        len_s;
  logic              in_ready_s, out_valid_s, accept_s, emit_s, emit_run_s;
  logic [ACC_W-1:0]  cw_ext_s, base_acc_s, placed_s;
  logic [FILL_W-1:0] base_fill_s, shift_up_s;

  assign sum_s    = {1'b0, bus.in_value} + (20'd1 << bus.in_k);
  assign len_s    = code_len(msb_index(sum_s), bus.in_k);
  assign cw_ext_s = {{(ACC_W-20){1'b0}}, sum_s};

  // alive_r keeps in_ready low while reset is held and on the first cycle after it.
  assign in_ready_s = alive_r & (state_r == ST_RUN) & (fill_r < WORD_BITS) & ~flush_pend_r;
  assign accept_s   = bus.in_valid & in_ready_s;
  assign emit_s     = out_valid_s & bus.out_ready;
  assign emit_run_s = emit_s & (state_r == ST_RUN);

  // An emit in the same cycle as an accept shifts first, then appends at fill-32.
  assign base_acc_s  = emit_run_s ? (acc_r << OUT_W) : acc_r;
  assign base_fill_s = emit_run_s ? (fill_r - WORD_BITS) : fill_r;
  // sum < 2^L, so pushing it to the top and back down by fill lands exactly
  // L bits below the current valid region with zeros elsewhere.
  assign shift_up_s  = ACC_BITS - {{(FILL_W-6){1'b0}}, len_s};
  assign placed_s    = (cw_ext_s << shift_up_s) >> base_fill_s;

  // Output qualification per state.
  always_comb begin
    out_valid_s = 1'b0;
    case (state_r)
      ST_RUN:   out_valid_s = (fill_r >= WORD_BITS);
      ST_DRAIN: out_valid_s = (fill_r != {FILL_W{1'b0}});
      ST_DONE:  out_valid_s = 1'b0;
      default:  out_valid_s = 1'b0;
    endcase
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_s;
  assign bus.out_data   = acc_r[ACC_W-1 -: OUT_W];
  assign bus.out_last   = (state_r == ST_DRAIN) & (fill_r != {FILL_W{1'b0}});
  assign bus.flush_done = (state_r == ST_DONE);
  assign bus.bits_total = bits_total_r;

  // Next-state logic for accumulator, fill level, flush tracking and FSM.
  always_comb begin
    acc_n_s        = acc_r;
    fill_n_s       = fill_r;
    state_n_s      = state_r;
    flush_pend_n_s = flush_pend_r;
    case (state_r)
      ST_RUN: begin
        if (accept_s) begin
          acc_n_s  = base_acc_s | placed_s;
          fill_n_s = base_fill_s + {{(FILL_W-6){1'b0}}, len_s};
        end else begin
          acc_n_s  = base_acc_s;
          fill_n_s = base_fill_s;
        end
        if (bus.flush_req & ~flush_pend_r) begin
          flush_pend_n_s = 1'b1;
        end else begin
          flush_pend_n_s = flush_pend_r;
        end
        // Full words leave in RUN; only the sub-word tail goes through DRAIN.
        if (flush_pend_r & (fill_r < WORD_BITS)) begin
          state_n_s = ST_DRAIN;
        end else begin
          state_n_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (fill_r == {FILL_W{1'b0}}) begin
          state_n_s = ST_DONE;
        end else if (emit_s) begin
          acc_n_s   = {ACC_W{1'b0}};
          fill_n_s  = {FILL_W{1'b0}};
          state_n_s = ST_DONE;
        end else begin
          state_n_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        flush_pend_n_s = 1'b0;
        state_n_s      = ST_RUN;
      end
      default: begin
        acc_n_s        = {ACC_W{1'b0}};
        fill_n_s       = {FILL_W{1'b0}};
        flush_pend_n_s = 1'b0;
        state_n_s      = ST_RUN;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r        <= {ACC_W{1'b0}};
      fill_r       <= {FILL_W{1'b0}};
      state_r      <= ST_RUN;
      flush_pend_r <= 1'b0;
      bits_total_r <= 32'd0;
      alive_r      <= 1'b0;
    end else begin
      acc_r        <= acc_n_s;
      fill_r       <= fill_n_s;
      state_r      <= state_n_s;
      flush_pend_r <= flush_pend_n_s;
      bits_total_r <= bits_total_r + (accept_s ? {26'd0, len_s} : 32'd0);
      alive_r      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_exp_golomb_packer.sv
// tb_exp_golomb_packer
//   Directed bench for exp_golomb_packer: a table of single-symbol + flush
//   vectors followed by hand-written multi-symbol, backpressure and reset
//   sequences. Expected words are hand-computed from the codeword definition.
module tb_exp_golomb_packer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  exp_golomb_packer_if bus();

  exp_golomb_packer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int word_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  logic [32:0] words[$];

  // Capture word handshakes and flush_done pulses half a cycle before the edge.
  always @(negedge clk) begin
    cyc++;
    if (reset_n && bus.out_valid && bus.out_ready) begin
      words.push_back({bus.out_last, bus.out_data});
      word_cyc = cyc;
    end
    if (reset_n && bus.flush_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expect_word(input string name, input int idx, input logic [32:0] exp);
    checks++;
    if (idx >= words.size()) begin
      errors++;
      $display("FAIL %s word %0d missing expected last=%b data=%h", name, idx, exp[32], exp[31:0]);
    end else if (words[idx] !== exp) begin
      errors++;
      $display("FAIL %s word %0d actual last=%b data=%h expected last=%b data=%h",
               name, idx, words[idx][32], words[idx][31:0], exp[32], exp[31:0]);
    end
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.flush_req = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check("reset_flags", {28'd0, bus.in_ready, bus.out_valid, bus.out_last, bus.flush_done}, 32'd0);
    check("reset_data", bus.out_data, 32'd0);
    check("reset_bits", bus.bits_total, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    words.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  // Called 1 time unit after a rising edge; returns the same way.
  task automatic send(input logic [18:0] v, input logic [2:0] k);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    bus.in_value = v;
    bus.in_k     = k;
    bus.in_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout value=%0d k=%0d in_ready never rose", v, k);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic flush_and_wait();
    int n;
    n = 0;
    done_cnt = 0;
    bus.flush_req = 1'b1;
    @(posedge clk); #1;
    bus.flush_req = 1'b0;
    while (done_cnt == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL flush_timeout actual=no flush_done expected=pulse");
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [18:0] value;
    logic [2:0]  k;
    logic [31:0] word;
    logic        last;
    logic [31:0] bits;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_value  = 19'd0;
    bus.in_k      = 3'd0;
    bus.flush_req = 1'b0;
    bus.out_ready = 1'b1;

    tbl[0] = '{19'd0,      3'd0, 32'h80000000, 1'b1, 32'd1};
    tbl[1] = '{19'd3,      3'd0, 32'h20000000, 1'b1, 32'd5};
    tbl[2] = '{19'd1,      3'd0, 32'h40000000, 1'b1, 32'd3};
    tbl[3] = '{19'd0,      3'd3, 32'h80000000, 1'b1, 32'd4};
    tbl[4] = '{19'd7,      3'd3, 32'hF0000000, 1'b1, 32'd4};
    tbl[5] = '{19'd8,      3'd3, 32'h40000000, 1'b1, 32'd6};
    tbl[6] = '{19'd1000,   3'd2, 32'h01F60000, 1'b1, 32'd17};
    tbl[7] = '{19'd524287, 3'd7, 32'h0008007F, 1'b0, 32'd32};

    // Single symbol then flush: one word, padded, tagged unless exactly 32 bits.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      send(tbl[i].value, tbl[i].k);
      flush_and_wait();
      check($sformatf("tbl%0d_count", i), 32'(words.size()), 32'd1);
      expect_word($sformatf("tbl%0d", i), 0, {tbl[i].last, tbl[i].word});
      check($sformatf("tbl%0d_bits", i), bus.bits_total, tbl[i].bits);
      if (tbl[i].last) begin
        check($sformatf("tbl%0d_done_lat", i), 32'(done_cyc - word_cyc), 32'd1);
      end
    end

    // 32 one-bit codewords fill exactly one word; flush then has nothing to pad.
    do_reset();
    for (int i = 0; i < 32; i++) send(19'd0, 3'd0);
    flush_and_wait();
    check("ones_count", 32'(words.size()), 32'd1);
    expect_word("ones", 0, {1'b0, 32'hFFFFFFFF});
    check("ones_bits", bus.bits_total, 32'd32);

    // 01001 then 10 -> 0100110 padded.
    do_reset();
    send(19'd5, 3'd2);
    send(19'd0, 3'd1);
    flush_and_wait();
    check("pair_count", 32'(words.size()), 32'd1);
    expect_word("pair", 0, {1'b1, 32'h4C000000});
    check("pair_bits", bus.bits_total, 32'd7);

    // Two maximum-length codewords (39 bits, single 1 at offset 19 each).
    do_reset();
    bus.out_ready = 1'b0;
    send(19'd524287, 3'd0);
    @(negedge clk);
    check("max_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    check("max_first_data", bus.out_data, 32'h00001000);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(19'd524287, 3'd0);
    flush_and_wait();
    check("max_count", 32'(words.size()), 32'd3);
    expect_word("max", 0, {1'b0, 32'h00001000});
    expect_word("max", 1, {1'b0, 32'h00000020});
    expect_word("max", 2, {1'b1, 32'h00000000});
    check("max_bits", bus.bits_total, 32'd78);

    // 40 buffered bits held under backpressure for 10 cycles.
    do_reset();
    bus.out_ready = 1'b0;
    send(19'd0, 3'd0);
    send(19'd524287, 3'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall_data", bus.out_data, 32'h80000800);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    flush_and_wait();
    check("stall_count", 32'(words.size()), 32'd2);
    expect_word("stall", 0, {1'b0, 32'h80000800});
    expect_word("stall", 1, {1'b1, 32'h00000000});
    check("stall_bits", bus.bits_total, 32'd40);

    // Asynchronous reset while the final word is waiting in DRAIN.
    do_reset();
    bus.out_ready = 1'b0;
    send(19'd0, 3'd0);
    bus.flush_req = 1'b1;
    @(posedge clk); #1;
    bus.flush_req = 1'b0;
    begin
      int n;
      n = 0;
      while (!(bus.out_valid && bus.out_last) && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("drain_last_word", {30'd0, bus.out_valid, bus.out_last}, 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_flags", {28'd0, bus.in_ready, bus.out_valid, bus.out_last, bus.flush_done}, 32'd0);
    check("arst_data", bus.out_data, 32'd0);
    check("arst_bits", bus.bits_total, 32'd0);
    do_reset();
    bus.out_ready = 1'b1;
    send(19'd0, 3'd0);
    flush_and_wait();
    check("post_arst_count", 32'(words.size()), 32'd1);
    expect_word("post_arst", 0, {1'b1, 32'h80000000});
    check("post_arst_bits", bus.bits_total, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
